// File: rtl/g15_photo_pkg.sv
// Shared types and constants for the G-15 photoelectric tape reader model.
package g15_photo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        HOLE,
        GAP
    } reader_state_e;

    typedef enum logic {
        DIR_FWD,
        DIR_REV
    } dir_e;

    localparam int FRAME_W = 5;

endpackage

// File: rtl/g15_tape_ram.sv
// Tape image store: synchronous write port, registered (1-clock) read port.
module g15_tape_ram
    import g15_photo_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [ADDR_W-1:0]  waddr_i,
    input  logic [FRAME_W-1:0] wdata_i,
    input  logic               re_i,
    input  logic [ADDR_W-1:0]  raddr_i,
    output logic [FRAME_W-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [FRAME_W-1:0] mem_q [DEPTH];
    logic [FRAME_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/g15_photo_reader.sv
// Photoelectric tape reader responder: plays a host-loaded tape image onto the
// PL6 photo-cell lines under forward/reverse tape-motion commands.
module g15_photo_reader
    import g15_photo_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int FRAME_PERIOD = 4000,
    parameter int HOLE_WIDTH   = 1000,
    parameter int START_DELAY  = 20000
) (
    input  logic               CLOCK,
    input  logic               rst,
    input  logic               tape_fwd,
    input  logic               tape_rev,
    input  logic               mount,
    input  logic               unmount,
    input  logic [ADDR_W:0]    tape_len,
    input  logic               load_we,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [FRAME_W-1:0] load_data,
    output logic [FRAME_W-1:0] photo,
    output logic               permit,
    output logic               at_bot,
    output logic               at_eot,
    output logic [ADDR_W:0]    position,
    output logic               busy
);

    localparam int CNT_MAX = (START_DELAY > FRAME_PERIOD) ? START_DELAY : FRAME_PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  SD_LOAD   = CNT_W'(START_DELAY - 1);
    localparam logic [CNT_W-1:0]  HOLE_LOAD = CNT_W'(HOLE_WIDTH - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(FRAME_PERIOD - HOLE_WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W:0]   POS_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   LEN_MAX   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    reader_state_e      state_q, state_d;
    dir_e               dir_q, dir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]    pos_q, pos_d;
    logic [ADDR_W:0]    len_q, len_d;
    logic               mounted_q, mounted_d;
    logic               at_bot_q, at_bot_d;
    logic               at_eot_q, at_eot_d;
    logic               permit_q, permit_d;

    logic               run_f, run_r, run_dir, limit_ok;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic [FRAME_W-1:0] rd_data;

    assign run_f    = mounted_q & tape_fwd & ~tape_rev;
    assign run_r    = mounted_q & tape_rev & ~tape_fwd;
    assign run_dir  = (dir_q == DIR_FWD) ? run_f : run_r;
    assign limit_ok = (dir_q == DIR_FWD) ? (pos_q < len_q) : (pos_q != '0);
    // Reverse motion reads the frame just behind the head.
    assign rd_addr  = (dir_q == DIR_FWD) ? pos_q[ADDR_W-1:0] : (pos_q[ADDR_W-1:0] - ADDR_ONE);

    g15_tape_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (CLOCK),
        .we_i    (load_we & ~mounted_q),
        .waddr_i (load_addr),
        .wdata_i (load_data),
        .re_i    (rd_en),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
        pos_d     = pos_q;
        len_d     = len_q;
        mounted_d = mounted_q;
        rd_en     = 1'b0;

        case (state_q)
            IDLE: begin
                if (unmount) begin
                    mounted_d = 1'b0;
                end else if (mount) begin
                    mounted_d = 1'b1;
                    len_d     = (tape_len > LEN_MAX) ? LEN_MAX : tape_len;
                    pos_d     = '0;
                end else if (run_f && (pos_q < len_q)) begin
                    dir_d   = DIR_FWD;
                    cnt_d   = SD_LOAD;
                    state_d = START;
                end else if (run_r && (pos_q != '0)) begin
                    dir_d   = DIR_REV;
                    cnt_d   = SD_LOAD;
                    state_d = START;
                end
            end
            START: begin
                if (!run_dir) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    rd_en   = 1'b1;
                    cnt_d   = HOLE_LOAD;
                    state_d = HOLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            HOLE: begin
                if (cnt_q == '0) begin
                    pos_d   = (dir_q == DIR_FWD) ? (pos_q + POS_ONE) : (pos_q - POS_ONE);
                    cnt_d   = GAP_LOAD;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    if (run_dir && limit_ok) begin
                        rd_en   = 1'b1;
                        cnt_d   = HOLE_LOAD;
                        state_d = HOLE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        at_bot_d = (pos_d == '0);
        at_eot_d = (pos_d == len_d);
        permit_d = mounted_d & ~at_eot_d;
    end

    always_ff @(posedge CLOCK) begin
        if (!rst) begin
            state_q   <= IDLE;
            dir_q     <= DIR_FWD;
            cnt_q     <= '0;
            pos_q     <= '0;
            len_q     <= '0;
            mounted_q <= 1'b0;
            at_bot_q  <= 1'b1;
            at_eot_q  <= 1'b1;
            permit_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            pos_q     <= pos_d;
            len_q     <= len_d;
            mounted_q <= mounted_d;
            at_bot_q  <= at_bot_d;
            at_eot_q  <= at_eot_d;
            permit_q  <= permit_d;
        end
    end

    // The read data register holds the frame for the whole hole; outside it the lines are dark.
    assign photo    = (state_q == HOLE) ? rd_data : '0;
    assign permit   = permit_q;
    assign at_bot   = at_bot_q;
    assign at_eot   = at_eot_q;
    assign position = pos_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_g15_photo_reader.sv
// Scoreboard bench for g15_photo_reader: expected frames are queued as runs are
// commanded and checked (value, hold width, spacing) as the photo lines pulse.
module tb_g15_photo_reader;

    localparam int ADDR_W = 4;
    localparam int FP     = 8;
    localparam int HW     = 3;
    localparam int SD     = 5;

    logic              CLOCK = 1'b0;
    logic              rst = 1'b0;
    logic              tape_fwd = 1'b0;
    logic              tape_rev = 1'b0;
    logic              mount = 1'b0;
    logic              unmount = 1'b0;
    logic [ADDR_W:0]   tape_len = '0;
    logic              load_we = 1'b0;
    logic [ADDR_W-1:0] load_addr = '0;
    logic [4:0]        load_data = '0;
    logic [4:0]        photo;
    logic              permit;
    logic              at_bot;
    logic              at_eot;
    logic [ADDR_W:0]   position;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int exp_q[$];
    int run_frames = 0;
    int last_start = 0;
    int hold = 0;
    bit trunc_ok = 1'b0;
    logic [4:0] prev_photo = '0;

    g15_photo_reader #(
        .ADDR_W       (ADDR_W),
        .FRAME_PERIOD (FP),
        .HOLE_WIDTH   (HW),
        .START_DELAY  (SD)
    ) dut (
        .CLOCK     (CLOCK),
        .rst       (rst),
        .tape_fwd  (tape_fwd),
        .tape_rev  (tape_rev),
        .mount     (mount),
        .unmount   (unmount),
        .tape_len  (tape_len),
        .load_we   (load_we),
        .load_addr (load_addr),
        .load_data (load_data),
        .photo     (photo),
        .permit    (permit),
        .at_bot    (at_bot),
        .at_eot    (at_eot),
        .position  (position),
        .busy      (busy)
    );

    always #5 CLOCK = ~CLOCK;
    always @(posedge CLOCK) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Frame monitor: scoreboard pop on each rising pulse, plus hold and spacing.
    always @(negedge CLOCK) begin
        if (photo != 5'd0) begin
            if (prev_photo == 5'd0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", int'(photo), 0);
                end else begin
                    check("frame", int'(photo), exp_q.pop_front());
                end
                if (run_frames > 0) begin
                    check("spacing", cyc - last_start, FP);
                end
                last_start = cyc;
                run_frames++;
                hold = 1;
            end else begin
                check("hold_stable", int'(photo), int'(prev_photo));
                hold++;
            end
        end else if (prev_photo != 5'd0) begin
            if (trunc_ok) begin
                trunc_ok = 1'b0;
            end else begin
                check("hold_len", hold, HW);
            end
        end
        prev_photo = photo;
    end

    task automatic load(input int addr, input int data);
        @(negedge CLOCK);
        load_we   = 1'b1;
        load_addr = ADDR_W'(addr);
        load_data = 5'(data);
        @(negedge CLOCK);
        load_we   = 1'b0;
    endtask

    task automatic pulse_mount(input int len);
        @(negedge CLOCK);
        mount    = 1'b1;
        tape_len = (ADDR_W + 1)'(len);
        @(negedge CLOCK);
        mount    = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while (busy && n < max) begin
            @(negedge CLOCK);
            n++;
        end
        check(tag, int'(busy), 0);
    endtask

    task automatic wait_photo(input string tag, input int val, input int max);
        int n = 0;
        while (int'(photo) != val && n < max) begin
            @(negedge CLOCK);
            n++;
        end
        check(tag, int'(photo), val);
    endtask

    task automatic expect_no_motion(input string tag, input int ncyc);
        bit saw = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge CLOCK);
            if (busy || photo != 5'd0) saw = 1'b1;
        end
        check(tag, int'(saw), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge CLOCK);
        check("rst_photo", int'(photo), 0);
        check("rst_permit", int'(permit), 0);
        check("rst_at_bot", int'(at_bot), 1);
        check("rst_at_eot", int'(at_eot), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_position", int'(position), 0);
        rst = 1'b1;

        load(0, 5'h01);
        load(1, 5'h1F);
        load(2, 5'h0A);
        pulse_mount(3);
        @(negedge CLOCK);
        check("mount_permit", int'(permit), 1);
        check("mount_at_eot", int'(at_eot), 0);
        check("mount_position", int'(position), 0);

        // Forward playback with start latency check.
        exp_q = '{5'h01, 5'h1F, 5'h0A};
        run_frames = 0;
        tape_fwd = 1'b1;
        repeat (SD) @(negedge CLOCK);
        check("lat_pre", int'(photo), 0);
        @(negedge CLOCK);
        check("lat_first", int'(photo), 5'h01);
        wait_idle("fwd_idle", 100);
        check("fwd_position", int'(position), 3);
        check("fwd_at_eot", int'(at_eot), 1);
        check("fwd_permit", int'(permit), 0);
        check("fwd_queue", exp_q.size(), 0);
        tape_fwd = 1'b0;
        @(negedge CLOCK);

        // Reverse playback.
        exp_q = '{5'h0A, 5'h1F, 5'h01};
        run_frames = 0;
        tape_rev = 1'b1;
        @(negedge CLOCK);
        wait_idle("rev_idle", 100);
        check("rev_position", int'(position), 0);
        check("rev_at_bot", int'(at_bot), 1);
        check("rev_permit", int'(permit), 1);
        check("rev_queue", exp_q.size(), 0);
        tape_rev = 1'b0;
        @(negedge CLOCK);

        // Stop during the first hole clock of frame 1.
        exp_q = '{5'h01, 5'h1F};
        run_frames = 0;
        tape_fwd = 1'b1;
        wait_photo("stop_see_f1", 5'h1F, 60);
        tape_fwd = 1'b0;
        @(negedge CLOCK);
        wait_idle("stop_idle", 60);
        repeat (FP) @(negedge CLOCK);
        check("stop_position", int'(position), 2);
        check("stop_queue", exp_q.size(), 0);

        // Conflicting commands stay idle.
        tape_fwd = 1'b1;
        tape_rev = 1'b1;
        expect_no_motion("conflict_idle", 20);
        check("conflict_position", int'(position), 2);
        tape_fwd = 1'b0;
        tape_rev = 1'b0;

        // Back to BOT, then reverse at the limit.
        exp_q = '{5'h1F, 5'h01};
        run_frames = 0;
        tape_rev = 1'b1;
        @(negedge CLOCK);
        wait_idle("rev2_idle", 100);
        check("rev2_position", int'(position), 0);
        tape_rev = 1'b0;
        @(negedge CLOCK);
        tape_rev = 1'b1;
        expect_no_motion("rev_at_bot_idle", 20);
        tape_rev = 1'b0;

        // Write while mounted is ignored; mount while busy is ignored.
        load(0, 5'h15);
        exp_q = '{5'h01, 5'h1F, 5'h0A};
        run_frames = 0;
        tape_fwd = 1'b1;
        repeat (3) @(negedge CLOCK);
        pulse_mount(1);
        wait_idle("gate_idle", 100);
        check("gate_position", int'(position), 3);
        check("gate_at_eot", int'(at_eot), 1);
        check("gate_queue", exp_q.size(), 0);
        tape_fwd = 1'b0;
        @(negedge CLOCK);

        // Reset in the middle of a hole.
        exp_q = '{5'h0A};
        run_frames = 0;
        tape_rev = 1'b1;
        wait_photo("rst_see_frame", 5'h0A, 60);
        trunc_ok = 1'b1;
        rst = 1'b0;
        @(negedge CLOCK);
        check("mid_rst_photo", int'(photo), 0);
        check("mid_rst_permit", int'(permit), 0);
        check("mid_rst_position", int'(position), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_at_eot", int'(at_eot), 1);
        rst = 1'b1;
        tape_rev = 1'b0;
        tape_fwd = 1'b1;
        expect_no_motion("unmounted_idle", 15);
        tape_fwd = 1'b0;
        check("final_queue", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/g15_photo_reader.md
Name: g15_photo_reader

Overview:
- Behavioural responder for the built-in photoelectric tape reader on connector PL6, driven by the G-15 tape-motion commands.
- Holds a host-loaded tape image and plays 5-bit frames onto the photo-cell lines at a programmable rate.
- Supports forward and reverse motion, motor start delay, and beginning/end-of-tape (BOT/EOT) limits.
- Lives beside io_top in the top level. It drives the signals that feed PL6_PHOTO1..5 and PHOTO_READER_PERMIT.

Parameters:
- ADDR_W, 12, tape image address width (depth 2**ADDR_W frames)
- FRAME_PERIOD, 4000, clocks from one frame start to the next (>= HOLE_WIDTH+2)
- HOLE_WIDTH, 1000, clocks each frame is held on the photo lines (>= 1)
- START_DELAY, 20000, motor acceleration clocks before the first frame (>= 1)

Ports:
- CLOCK  in  1  system clock; the only clock
- rst  in  1  synchronous, active-low reset
- tape_fwd  in  1  forward command (from PL6_PHOTO_TAPE_FWD)
- tape_rev  in  1  reverse command (from PL6_PHOTO_TAPE_REV)
- mount  in  1  one-clock pulse: mount tape, position := 0
- unmount  in  1  one-clock pulse: unmount tape
- tape_len  in  ADDR_W+1  number of valid frames; sampled on mount
- load_we  in  1  tape image write strobe
- load_addr  in  ADDR_W  tape image write address
- load_data  in  5  frame to write; bit0 = channel 1
- photo  out  5  photo-cell lines; bit0 = PL6_PHOTO1
- permit  out  1  PHOTO_READER_PERMIT
- at_bot  out  1  position == 0
- at_eot  out  1  position == length
- position  out  ADDR_W+1  current tape position (index of the next forward frame)
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0 at an edge):
  - state IDLE; photo=0; permit=0; mounted=0; position=0; length=0; counter=0.
  - at_bot=1, at_eot=1 (length 0), busy=0.
  - Reset mid-frame truncates the pulse immediately.
- States: IDLE, START, HOLE, GAP. A direction register dir (fwd/rev) is latched on leaving IDLE.
- Command decode: run_f = mounted & tape_fwd & ~tape_rev; run_r = mounted & tape_rev & ~tape_fwd. Both commands asserted counts as stop.
- IDLE:
  - run_f with position<length: dir:=fwd, counter:=START_DELAY-1, go to START.
  - run_r with position>0: dir:=rev, same load, go to START.
  - Otherwise remain in IDLE.
- START:
  - Counter decrements each clock.
  - Command for dir dropped: go to IDLE.
  - Counter==0: go to HOLE, photo:=frame, counter:=HOLE_WIDTH-1.
  - First photo assertion appears START_DELAY+1 clocks after the command is first sampled high.
- Frame address: fwd reads position; rev reads position-1. The RAM read is issued in the last START/GAP cycle so data is ready on HOLE entry.
- HOLE:
  - photo is held stable for exactly HOLE_WIDTH clocks. A command drop does not truncate it.
  - On exit: photo:=0, position := position+1 (fwd) or -1 (rev), counter:=FRAME_PERIOD-HOLE_WIDTH-1, go to GAP.
- GAP, at counter==0:
  - Command for dir still valid and the limit is not reached: go to HOLE with the next frame.
  - Otherwise go to IDLE.
  - Limits: fwd requires position<length; rev requires position>0.
  - A direction change needs IDLE and a fresh START_DELAY.
- Frame spacing while running is exactly FRAME_PERIOD clocks.
- Limits:
  - Forward run stops after the frame at length-1 and sets at_eot.
  - Reverse run stops after frame 0 and sets at_bot.
  - Commands at a limit leave the block in IDLE with no frames emitted.
- permit = mounted & ~at_eot, registered.
- mount/unmount:
  - Honoured only in IDLE; ignored otherwise.
  - mount: mounted:=1, length:=tape_len (clamped to 2**ADDR_W), position:=0.
  - unmount: mounted:=0. If both pulse together, unmount wins.
- load_we:
  - Honoured only when ~mounted; ignored while mounted.
  - Writes RAM[load_addr] := load_data.
- position, at_bot, at_eot are registered and update the clock after the HOLE exit.

Decomposition:
- Shared package g15_photo_pkg holds the reader_state_e enum (IDLE, START, HOLE, GAP), the dir_e enum, and the frame width constant (5).
- One sub-module, g15_tape_ram: 2**ADDR_W x 5 simple dual-port RAM with a synchronous write port and a 1-clock synchronous read port.

Test Plan (FRAME_PERIOD=8, HOLE_WIDTH=3, START_DELAY=5, ADDR_W=4):
- Forward playback:
  - Stimulus: load frames 0x01,0x1F,0x0A; mount tape_len=3; tape_fwd=1.
  - Required: photo=0x01 for 3 clocks starting 6 clocks after fwd is sampled; then 0x1F and 0x0A at 8-clock spacing.
  - Then position=3, at_eot=1, permit=0, busy=0.
- Reverse playback:
  - Stimulus: from position=3, tape_rev=1.
  - Required: frames 0x0A, 0x1F, 0x01 in that order; final position=0, at_bot=1.
- Stop mid-frame:
  - Stimulus: drop tape_fwd during the first HOLE clock of frame 1.
  - Required: 0x1F is still held 3 clocks; no further frame; position=2; IDLE after the gap.
- Conflicting commands and limits:
  - Stimulus: fwd=rev=1 in IDLE.
  - Required: stays IDLE, photo=0.
  - Stimulus: rev at position 0.
  - Required: no frames.
- Load and mount gating:
  - Stimulus: load_we while mounted.
  - Required: RAM unchanged (replay shows old frames).
  - Stimulus: mount pulse while busy.
  - Required: ignored.
- Reset mid-operation:
  - Stimulus: rst=0 during HOLE.
  - Required: next clock photo=0, permit=0, position=0, mounted=0, state IDLE.
